mod_recon: RTL and testbench
============================

# mod_recon

Sequential modular-reconstruction unit: the inverse of the team's combinational modulus block. Given a quotient, divisor and remainder, it rebuilds the dividend a = q*b + rem with a bit-serial shift-add multiplier and a start/done handshake. It checks that the remainder is a legal residue of the divisor. It sits downstream of MOD/DIV datapaths as a self-check and reconstruction stage, taking one cycle per quotient bit to keep area small.

## Interface
- DATAWIDTH, 8: width of q, b and rem.
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  request. Operands are sampled on the edge where start=1 and ready=1.
- q  input  DATAWIDTH  quotient (unsigned).
- b  input  DATAWIDTH  divisor (unsigned).
- rem  input  DATAWIDTH  remainder (unsigned).
- ready  output  1  combinational; 1 in IDLE or DONE.
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- a  output  2*DATAWIDTH  reconstructed dividend q*b+rem.
- fits  output  1  1 when a[2*DATAWIDTH-1:DATAWIDTH]==0, i.e. a fits in DATAWIDTH bits.
- rem_ok  output  1  1 when b!=0 and rem<b.

## Operation
- FSM states and transitions:
  - IDLE: start → RUN; otherwise stay in IDLE.
  - RUN: after exactly DATAWIDTH iterations → DONE.
  - DONE: start → RUN (back-to-back accepted); otherwise → IDLE.
- Load (start accepted):
  - mq ← q.
  - mb ← {DATAWIDTH zeros, b}.
  - acc ← {DATAWIDTH zeros, rem}.
  - cnt ← 0.
  - rem_ok_r ← (b!=0)&&(rem<b), evaluated on the sampled operands.
- Each RUN cycle:
  - If mq[0], acc ← acc + mb.
  - mb ← mb<<1; mq ← mq>>1; cnt ← cnt+1.
- On the last RUN edge (cnt==DATAWIDTH-1):
  - a ← final acc value, including that cycle's add.
  - fits and rem_ok are updated from the same values.
  - done ← 1.
- Arithmetic width rules:
  - All arithmetic is unsigned, on 2*DATAWIDTH bits.
  - The maximum result, (2^DW-1)^2 + 2^DW - 1 = 2^(2DW) - 2^DW, fits in 2*DATAWIDTH bits, so no overflow is possible and no truncation occurs.
- Fixed latency: no early termination, even when q==0.
- Operand inputs are don't-care except on the accepting edge.
- a, fits and rem_ok hold their values until the next done; they do not change during RUN.
- start during RUN is ignored. It is not queued.
- b==0: result is a=rem, rem_ok=0. No error state.

## Timing
- Reset values: a=0, fits=0, rem_ok=0, done=0, busy=0, state=IDLE, ready=1.
- Rst has priority over all other activity. Asserted mid-RUN, it aborts the operation: no done pulse is issued, and all outputs return to their reset values on that edge.
- Latency: start accepted at edge E0 → busy=1 from E0 to E0+DATAWIDTH. The done pulse and new a appear after edge E0+DATAWIDTH and last one cycle.
- Throughput: with start held high in DONE, the next operation begins at edge E0+DATAWIDTH+1, giving one result per DATAWIDTH+1 cycles.
- done is high for exactly one cycle per accepted start.
- busy and done are never high together.

## Test plan
- Reset: hold Rst 2 cycles → a=0, fits=0, rem_ok=0, done=0, busy=0, ready=1.
- DW=8, q=25, b=7, rem=4 → done exactly 8 cycles after the accept edge; a=179, fits=1, rem_ok=1.
- DW=8, q=255, b=255, rem=254 → a=0xFEFF, fits=0, rem_ok=1. Separately, q=0, b=200, rem=250 → a=250, rem_ok=0.
- b=0, q=9, rem=3 → a=3, rem_ok=0, done still pulses after 8 cycles.
- Back-to-back: start held high across two operations (10×10+3, then 1×1+0) → done pulses 9 cycles apart with a=103, then a=1. A start pulsed mid-RUN is ignored, and no extra done appears.
- Reset mid-op: assert Rst at cycle 4 of RUN → no done; outputs return to reset values. A new start after Rst deasserts (q=3, b=5, rem=2) → a=17.

Source files
------------

// File: rtl/mod_recon.sv
// mod_recon: rebuilds a dividend a = q*b + rem from quotient, divisor and
// remainder using a bit-serial shift-add multiplier (one quotient bit per
// cycle), and flags whether rem is a legal residue of b.
module mod_recon #(
  parameter int DATAWIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic [DATAWIDTH-1:0]     q,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     rem,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [2*DATAWIDTH-1:0]   a,
  output logic                     fits,
  output logic                     rem_ok
);

  localparam int W2 = 2 * DATAWIDTH;
  // One extra bit so the counter stays legal even for tiny widths.
  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATAWIDTH-1:0]  mq_q, mq_d;
  logic [W2-1:0]         mb_q, mb_d;
  logic [W2-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ok_samp_q, ok_samp_d;
  logic [W2-1:0]         a_q, a_d;
  logic                  fits_q, fits_d;
  logic                  rem_ok_q, rem_ok_d;
  logic                  done_q, done_d;

  logic                  accept_s;
  logic                  last_s;
  logic [W2-1:0]         acc_sum_s;

  // Handshake decode and FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is ignored here; the operation always runs full length.
        if (cnt_q == CNT_LAST) begin
          last_s  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shift-add datapath: load on accept, one quotient bit per RUN cycle,
  // publish results only on the final iteration.
  always_comb begin
    mq_d      = mq_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ok_samp_d = ok_samp_q;
    a_d       = a_q;
    fits_d    = fits_q;
    rem_ok_d  = rem_ok_q;
    done_d    = 1'b0;

    if (mq_q[0]) begin
      acc_sum_s = acc_q + mb_q;
    end else begin
      acc_sum_s = acc_q;
    end

    if (accept_s) begin
      mq_d      = q;
      mb_d      = {{DATAWIDTH{1'b0}}, b};
      acc_d     = {{DATAWIDTH{1'b0}}, rem};
      cnt_d     = CNT_ZERO;
      ok_samp_d = (b != {DATAWIDTH{1'b0}}) && (rem < b);
    end else if (state_q == ST_RUN) begin
      acc_d = acc_sum_s;
      mb_d  = mb_q << 1;
      mq_d  = mq_q >> 1;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      acc_d = acc_q;
    end

    if (last_s) begin
      a_d      = acc_sum_s;
      fits_d   = (acc_sum_s[W2-1:DATAWIDTH] == {DATAWIDTH{1'b0}});
      rem_ok_d = ok_samp_q;
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  // State and datapath registers; Rst wins over everything, including a RUN in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      mq_q      <= {DATAWIDTH{1'b0}};
      mb_q      <= {W2{1'b0}};
      acc_q     <= {W2{1'b0}};
      cnt_q     <= CNT_ZERO;
      ok_samp_q <= 1'b0;
      a_q       <= {W2{1'b0}};
      fits_q    <= 1'b0;
      rem_ok_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mq_q      <= mq_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ok_samp_q <= ok_samp_d;
      a_q       <= a_d;
      fits_q    <= fits_d;
      rem_ok_q  <= rem_ok_d;
      done_q    <= done_d;
    end
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign a      = a_q;
  assign fits   = fits_q;
  assign rem_ok = rem_ok_q;

endmodule

// File: tb/tb_mod_recon.sv
// tb_mod_recon: directed self-checking bench for mod_recon (DATAWIDTH=8).
module tb_mod_recon;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [7:0]  q;
  logic [7:0]  b;
  logic [7:0]  rem;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] a;
  logic        fits;
  logic        rem_ok;

  int pass_cnt;
  int chk_cnt;
  logic [15:0] prev_a;

  mod_recon #(.DATAWIDTH(8)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .q      (q),
    .b      (b),
    .rem    (rem),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .a      (a),
    .fits   (fits),
    .rem_ok (rem_ok)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a"},      32'(a),      32'd0);
    chk({tag, "_fits"},   32'(fits),   32'd0);
    chk({tag, "_rem_ok"}, 32'(rem_ok), 32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_ready"},  32'(ready),  32'd1);
  endtask

  // One full operation with a single-cycle start pulse.
  task automatic run_op(input string tag, input logic [7:0] q_v, input logic [7:0] b_v,
                        input logic [7:0] rem_v, input logic [15:0] exp_a,
                        input logic exp_fits, input logic exp_ok);
    int cyc;
    start = 1'b1; q = q_v; b = b_v; rem = rem_v;
    tick;
    start = 1'b0; q = 8'($urandom); b = 8'($urandom); rem = 8'($urandom);
    chk({tag, "_busy"},  32'(busy),  32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (cyc == 4) chk({tag, "_hold"}, 32'(a), 32'(prev_a));
      tick;
      cyc++;
    end
    chk({tag, "_lat"},    32'(cyc),    32'd8);
    chk({tag, "_a"},      32'(a),      32'(exp_a));
    chk({tag, "_fits"},   32'(fits),   32'(exp_fits));
    chk({tag, "_rem_ok"}, 32'(rem_ok), 32'(exp_ok));
    chk({tag, "_nobusy"}, 32'(busy),   32'd0);
    prev_a = exp_a;
    tick;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_keep"},  32'(a),    32'(exp_a));
  endtask

  initial begin
    int cyc;
    int dcount;
    pass_cnt = 0;
    chk_cnt  = 0;
    prev_a   = 16'd0;
    Rst = 1'b1; start = 1'b0; q = 8'd0; b = 8'd0; rem = 8'd0;
    tick;
    tick;
    chk_reset_state("reset");
    Rst = 1'b0;
    tick;

    run_op("basic",  8'd25,  8'd7,   8'd4,   16'd179,   1'b1, 1'b1);
    run_op("max",    8'd255, 8'd255, 8'd254, 16'hFEFF,  1'b0, 1'b1);
    run_op("q0",     8'd0,   8'd200, 8'd250, 16'd250,   1'b1, 1'b0);
    run_op("b0",     8'd9,   8'd0,   8'd3,   16'd3,     1'b1, 1'b0);
    run_op("remeqb", 8'd2,   8'd5,   8'd5,   16'd15,    1'b1, 1'b0);
    run_op("fit255", 8'd1,   8'd255, 8'd0,   16'd255,   1'b1, 1'b1);
    run_op("fit256", 8'd1,   8'd255, 8'd1,   16'd256,   1'b0, 1'b1);

    // Back-to-back: start held high across two operations.
    start = 1'b1; q = 8'd10; b = 8'd10; rem = 8'd3;
    tick;
    q = 8'd1; b = 8'd1; rem = 8'd0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("b2b1_lat",   32'(cyc),   32'd8);
    chk("b2b1_a",     32'(a),     32'd103);
    chk("b2b1_ready", 32'(ready), 32'd1);
    tick;
    chk("b2b2_done",  32'(done),  32'd0);
    chk("b2b2_busy",  32'(busy),  32'd1);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("b2b2_gap",    32'(cyc),    32'd9);
    chk("b2b2_a",      32'(a),      32'd1);
    chk("b2b2_rem_ok", 32'(rem_ok), 32'd1);
    prev_a = 16'd1;
    tick;

    // Start pulse during RUN must be ignored and must not add a done.
    start = 1'b1; q = 8'd6; b = 8'd4; rem = 8'd1;
    tick;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin
        start = 1'b1; q = 8'd50; b = 8'd50; rem = 8'd0;
      end else begin
        start = 1'b0;
      end
      tick;
      if (done === 1'b1) begin
        dcount++;
        chk("midstart_a", 32'(a), 32'd25);
        chk("midstart_lat", 32'(i), 32'd7);
      end
      if (busy === 1'b1 && done === 1'b1) chk("busy_done_excl", 32'd1, 32'd0);
    end
    chk("midstart_count", 32'(dcount), 32'd1);
    prev_a = 16'd25;

    // Reset in the middle of RUN aborts with no done pulse.
    start = 1'b1; q = 8'd200; b = 8'd100; rem = 8'd5;
    tick;
    start = 1'b0;
    tick; tick; tick;
    Rst = 1'b1;
    tick;
    chk_reset_state("midrst");
    Rst = 1'b0;
    prev_a = 16'd0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1) dcount++;
    end
    chk("midrst_nodone", 32'(dcount), 32'd0);
    run_op("after_rst", 8'd3, 8'd5, 8'd2, 16'd17, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
